// File: rtl/warp_fetch_scheduler_pkg.sv
// Shared front-end definitions for the warp fetch scheduler: sizing constants
// and the per-warp fetch state record.
package warp_fetch_scheduler_pkg;

   localparam int NUM_WARP     = 4;
   localparam int NUM_WARP_LOG = 2;
   localparam int SIZE_PC      = 32;
   localparam int IBUF_DEPTH   = 2;
   localparam int CREDIT_W     = $clog2(IBUF_DEPTH + 1);

   typedef logic [SIZE_PC-1:0]      pc_t;
   typedef logic [NUM_WARP_LOG-1:0] warp_id_t;
   typedef logic [CREDIT_W-1:0]     credit_t;

   localparam credit_t CREDIT_MAX = credit_t'(IBUF_DEPTH);

   typedef struct packed {
      logic    active;
      pc_t     pc;
      credit_t credit;
   } warp_fetch_state_t;

endpackage

// File: rtl/warp_fetch_scheduler_if.sv
// Control and fetch-request bundle between the CTA/issue logic, the scheduler
// and the instruction cache.
interface warp_fetch_scheduler_if;
   import warp_fetch_scheduler_pkg::*;

   logic                stall_i;
   logic [NUM_WARP-1:0] warpRunEnable_i;
   logic                ctaExit_i;
   warp_id_t            exitWarp_i;
   logic                reconv_i;
   warp_id_t            reconvWarp_i;
   pc_t                 reconvPC_i;
   logic                ibufRelease_i;
   warp_id_t            ibufReleaseWarp_i;
   logic                fetchValid_o;
   warp_id_t            fetchWarp_o;
   pc_t                 fetchPC_o;
   pc_t                 fetchPCadd1_o;
   logic [NUM_WARP-1:0] warpActive_o;

   modport master (
      output stall_i, warpRunEnable_i, ctaExit_i, exitWarp_i, reconv_i,
             reconvWarp_i, reconvPC_i, ibufRelease_i, ibufReleaseWarp_i,
      input  fetchValid_o, fetchWarp_o, fetchPC_o, fetchPCadd1_o, warpActive_o
   );

   modport slave (
      input  stall_i, warpRunEnable_i, ctaExit_i, exitWarp_i, reconv_i,
             reconvWarp_i, reconvPC_i, ibufRelease_i, ibufReleaseWarp_i,
      output fetchValid_o, fetchWarp_o, fetchPC_o, fetchPCadd1_o, warpActive_o
   );

endinterface

// File: rtl/warp_fetch_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from i_ptr+1 (wrapping) and grants the
// first requester, both one-hot and encoded.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int LOG = 2
) (
   input  logic [N-1:0]   i_req,
   input  logic [LOG-1:0] i_ptr,
   output logic [N-1:0]   o_grantOh,
   output logic [LOG-1:0] o_grantIdx,
   output logic           o_grantValid
);

   logic [LOG-1:0] w_idx;

   always_comb begin
      o_grantOh    = '0;
      o_grantIdx   = '0;
      o_grantValid = 1'b0;
      w_idx        = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = LOG'((int'(i_ptr) + k) % N);
         if (!o_grantValid && i_req[w_idx]) begin
            o_grantValid      = 1'b1;
            o_grantIdx        = w_idx;
            o_grantOh[w_idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Per-SM warp fetch scheduler: owns per-warp PC and credit state, picks one
// eligible warp per cycle round-robin and registers the cache PC pair.
module warp_fetch_scheduler
   import warp_fetch_scheduler_pkg::*;
(
   input logic                   clk,
   input logic                   reset,
   warp_fetch_scheduler_if.slave bus
);

   warp_fetch_state_t   r_warp [NUM_WARP];
   warp_fetch_state_t   w_warpNext [NUM_WARP];
   logic [NUM_WARP-1:0] r_enPrev;
   warp_id_t            r_rrPtr;
   logic                r_fetchValid;
   warp_id_t            r_fetchWarp;
   pc_t                 r_fetchPC;
   pc_t                 r_fetchPCadd1;

   logic [NUM_WARP-1:0] w_exitHit;
   logic [NUM_WARP-1:0] w_reconvHit;
   logic [NUM_WARP-1:0] w_releaseHit;
   logic [NUM_WARP-1:0] w_activate;
   logic [NUM_WARP-1:0] w_req;
   logic [NUM_WARP-1:0] w_grantOh;
   logic [NUM_WARP-1:0] w_granted;
   logic [NUM_WARP-1:0] w_overflow;
   warp_id_t            w_grantIdx;
   logic                w_grantValid;
   logic                w_grant;

   always_comb begin
      w_exitHit    = '0;
      w_reconvHit  = '0;
      w_releaseHit = '0;
      w_activate   = '0;
      w_req        = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         w_exitHit[w]    = bus.ctaExit_i && (bus.exitWarp_i == warp_id_t'(w));
         w_reconvHit[w]  = bus.reconv_i && (bus.reconvWarp_i == warp_id_t'(w));
         w_releaseHit[w] = bus.ibufRelease_i && (bus.ibufReleaseWarp_i == warp_id_t'(w));
         w_activate[w]   = bus.warpRunEnable_i[w] && !r_enPrev[w] && !r_warp[w].active;
         w_req[w]        = r_warp[w].active && (r_warp[w].credit != '0) &&
                           !w_reconvHit[w] && !w_exitHit[w];
      end
   end

   rr_arbiter #(
      .N   (NUM_WARP),
      .LOG (NUM_WARP_LOG)
   ) u_arbiter (
      .i_req        (w_req),
      .i_ptr        (r_rrPtr),
      .o_grantOh    (w_grantOh),
      .o_grantIdx   (w_grantIdx),
      .o_grantValid (w_grantValid)
   );

   assign w_grant   = w_grantValid && !bus.stall_i;
   assign w_granted = w_grant ? w_grantOh : '0;

   // Exit beats reconv beats activation; otherwise grant and release adjust credit.
   always_comb begin
      w_overflow = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         w_warpNext[w] = r_warp[w];
         if (w_exitHit[w]) begin
            w_warpNext[w].active = 1'b0;
            w_warpNext[w].credit = '0;
         end else if (w_reconvHit[w]) begin
            w_warpNext[w].pc     = bus.reconvPC_i;
            w_warpNext[w].credit = CREDIT_MAX;
         end else if (w_activate[w]) begin
            w_warpNext[w].active = 1'b1;
            w_warpNext[w].pc     = '0;
            w_warpNext[w].credit = CREDIT_MAX;
         end else begin
            if (w_granted[w]) begin
               w_warpNext[w].pc = r_warp[w].pc + pc_t'(2);
            end
            if (w_granted[w] && !w_releaseHit[w]) begin
               w_warpNext[w].credit = r_warp[w].credit - credit_t'(1);
            end else if (!w_granted[w] && w_releaseHit[w]) begin
               if (r_warp[w].credit == CREDIT_MAX) begin
                  w_overflow[w] = 1'b1;
               end else begin
                  w_warpNext[w].credit = r_warp[w].credit + credit_t'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < NUM_WARP; w++) begin
            r_warp[w] <= '0;
         end
         r_enPrev      <= '0;
         r_rrPtr       <= warp_id_t'(NUM_WARP - 1);
         r_fetchValid  <= 1'b0;
         r_fetchWarp   <= '0;
         r_fetchPC     <= '0;
         r_fetchPCadd1 <= '0;
      end else begin
         r_warp       <= w_warpNext;
         r_enPrev     <= bus.warpRunEnable_i;
         r_fetchValid <= w_grant;
         if (w_grant) begin
            r_rrPtr       <= w_grantIdx;
            r_fetchWarp   <= w_grantIdx;
            r_fetchPC     <= r_warp[w_grantIdx].pc;
            r_fetchPCadd1 <= r_warp[w_grantIdx].pc + pc_t'(1);
         end
      end
   end

   assign bus.fetchValid_o  = r_fetchValid;
   assign bus.fetchWarp_o   = r_fetchWarp;
   assign bus.fetchPC_o     = r_fetchPC;
   assign bus.fetchPCadd1_o = r_fetchPCadd1;

   always_comb begin
      bus.warpActive_o = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         bus.warpActive_o[w] = r_warp[w].active;
      end
   end

   // A credit return to a full instruction buffer means downstream lost track.
   aCreditOverflow : assert property (@(posedge clk) disable iff (!reset) w_overflow == '0);

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Self-checking bench for warp_fetch_scheduler against a per-warp behavioural
// model of PCs, credits and round-robin selection.
module tb_warp_fetch_scheduler;
   import warp_fetch_scheduler_pkg::*;

   logic clk;
   logic reset;
   warp_fetch_scheduler_if bus ();

   warp_fetch_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   bit                  mActive [NUM_WARP];
   logic [31:0]         mPc     [NUM_WARP];
   int                  mCredit [NUM_WARP];
   int                  mRrPtr;
   bit [NUM_WARP-1:0]   mPrevEn;
   bit                  expValid;
   int                  expWarp;
   logic [31:0]         expPC;
   bit [NUM_WARP-1:0]   expActive;

   task automatic modelReset();
      for (int w = 0; w < NUM_WARP; w++) begin
         mActive[w] = 1'b0;
         mPc[w]     = '0;
         mCredit[w] = 0;
      end
      mRrPtr    = NUM_WARP - 1;
      mPrevEn   = '0;
      expValid  = 1'b0;
      expWarp   = 0;
      expPC     = '0;
      expActive = '0;
   endtask

   task automatic idleInputs();
      bus.stall_i           = 1'b0;
      bus.ctaExit_i         = 1'b0;
      bus.exitWarp_i        = '0;
      bus.reconv_i          = 1'b0;
      bus.reconvWarp_i      = '0;
      bus.reconvPC_i        = '0;
      bus.ibufRelease_i     = 1'b0;
      bus.ibufReleaseWarp_i = '0;
   endtask

   // Advance the model using the inputs currently driven, then clock the DUT.
   task automatic cycle();
      int g = -1;
      if (!bus.stall_i) begin
         for (int k = 1; k <= NUM_WARP; k++) begin
            int w = (mRrPtr + k) % NUM_WARP;
            if (g < 0 && mActive[w] && mCredit[w] > 0 &&
                !(bus.reconv_i && int'(bus.reconvWarp_i) == w) &&
                !(bus.ctaExit_i && int'(bus.exitWarp_i) == w))
               g = w;
         end
      end
      expValid = (g >= 0);
      if (g >= 0) begin
         expWarp = g;
         expPC   = mPc[g];
         mRrPtr  = g;
      end
      for (int w = 0; w < NUM_WARP; w++) begin
         bit ex = bus.ctaExit_i && int'(bus.exitWarp_i) == w;
         bit rc = bus.reconv_i && int'(bus.reconvWarp_i) == w;
         bit rl = bus.ibufRelease_i && int'(bus.ibufReleaseWarp_i) == w;
         bit ac = bus.warpRunEnable_i[w] && !mPrevEn[w] && !mActive[w];
         if (ex) begin
            mActive[w] = 1'b0;
            mCredit[w] = 0;
         end else if (rc) begin
            mPc[w]     = bus.reconvPC_i;
            mCredit[w] = IBUF_DEPTH;
         end else if (ac) begin
            mActive[w] = 1'b1;
            mPc[w]     = '0;
            mCredit[w] = IBUF_DEPTH;
         end else begin
            if (w == g) mPc[w] = mPc[w] + 32'd2;
            mCredit[w] = mCredit[w] + (rl ? 1 : 0) - ((w == g) ? 1 : 0);
            if (mCredit[w] > IBUF_DEPTH) mCredit[w] = IBUF_DEPTH;
         end
      end
      mPrevEn = bus.warpRunEnable_i;
      for (int w = 0; w < NUM_WARP; w++) expActive[w] = mActive[w];
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idleInputs();
      bus.warpRunEnable_i = '0;
      modelReset();
      #12;
      checks++;
      if (bus.fetchValid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.fetchValid_o); end
      checks++;
      if (bus.fetchWarp_o !== '0) begin failures++; $display("[TB] FAIL reset_warp got=%0d exp=0", bus.fetchWarp_o); end
      checks++;
      if (bus.fetchPC_o !== '0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.fetchPC_o); end
      checks++;
      if (bus.fetchPCadd1_o !== '0) begin failures++; $display("[TB] FAIL reset_pcadd1 got=%h exp=0", bus.fetchPCadd1_o); end
      checks++;
      if (bus.warpActive_o !== '0) begin failures++; $display("[TB] FAIL reset_active got=%b exp=0", bus.warpActive_o); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int nFetch = 0;
      bus.warpRunEnable_i = 4'b0011;
      for (int c = 0; c < 7; c++) begin
         cycle();
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL basic_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (expValid) begin
            nFetch++;
            checks++;
            if (bus.fetchWarp_o !== warp_id_t'(expWarp) || bus.fetchPC_o !== expPC || bus.fetchPCadd1_o !== expPC + 32'd1) begin
               failures++; $display("[TB] FAIL basic_fetch c=%0d got=w%0d/%h/%h exp=w%0d/%h", c, bus.fetchWarp_o, bus.fetchPC_o, bus.fetchPCadd1_o, expWarp, expPC);
            end
         end
         checks++;
         if (bus.warpActive_o !== expActive) begin failures++; $display("[TB] FAIL basic_active got=%b exp=%b", bus.warpActive_o, expActive); end
      end
      checks++;
      if (nFetch !== 4) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=4", nFetch); end
   endtask

   task automatic test_release();
      int nW1 = 0;
      int relCycle = -1;
      for (int c = 0; c < 5; c++) begin
         bus.ibufRelease_i     = (c == 0);
         bus.ibufReleaseWarp_i = 2'd1;
         cycle();
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL release_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (expValid) begin
            checks++;
            if (bus.fetchWarp_o !== warp_id_t'(expWarp) || bus.fetchPC_o !== expPC) begin
               failures++; $display("[TB] FAIL release_fetch c=%0d got=w%0d/%h exp=w%0d/%h", c, bus.fetchWarp_o, bus.fetchPC_o, expWarp, expPC);
            end
         end
         if (bus.fetchValid_o === 1'b1 && bus.fetchWarp_o === 2'd1 && bus.fetchPC_o === 32'd4) begin
            nW1++;
            relCycle = c;
         end
      end
      idleInputs();
      checks++;
      if (nW1 !== 1 || relCycle !== 1) begin failures++; $display("[TB] FAIL release_w1 got=%0d@%0d exp=1@1", nW1, relCycle); end
   endtask

   task automatic test_reconv();
      int nW2 = 0;
      logic [31:0] firstPC = '1;
      logic [31:0] firstAdd1 = '1;
      bus.warpRunEnable_i = 4'b0111;
      for (int c = 0; c < 11; c++) begin
         idleInputs();
         if (c == 1) begin bus.reconv_i = 1'b1; bus.reconvWarp_i = 2'd2; bus.reconvPC_i = 32'h10; end
         if (c == 5) begin bus.reconv_i = 1'b1; bus.reconvWarp_i = 2'd2; bus.reconvPC_i = 32'h40; end
         cycle();
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL reconv_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (expValid) begin
            checks++;
            if (bus.fetchWarp_o !== warp_id_t'(expWarp) || bus.fetchPC_o !== expPC || bus.fetchPCadd1_o !== expPC + 32'd1) begin
               failures++; $display("[TB] FAIL reconv_fetch c=%0d got=w%0d/%h/%h exp=w%0d/%h", c, bus.fetchWarp_o, bus.fetchPC_o, bus.fetchPCadd1_o, expWarp, expPC);
            end
         end
         if (c >= 6 && bus.fetchValid_o === 1'b1 && bus.fetchWarp_o === 2'd2) begin
            if (nW2 == 0) begin firstPC = bus.fetchPC_o; firstAdd1 = bus.fetchPCadd1_o; end
            nW2++;
         end
      end
      idleInputs();
      checks++;
      if (firstPC !== 32'h40 || firstAdd1 !== 32'h41 || nW2 !== 2) begin
         failures++; $display("[TB] FAIL reconv_target got=%h/%h n=%0d exp=40/41 n=2", firstPC, firstAdd1, nW2);
      end
   endtask

   task automatic test_exit_reconv();
      int nW1 = 0;
      for (int c = 0; c < 6; c++) begin
         idleInputs();
         if (c == 0) begin
            bus.ctaExit_i = 1'b1; bus.exitWarp_i = 2'd1;
            bus.reconv_i = 1'b1; bus.reconvWarp_i = 2'd1; bus.reconvPC_i = 32'h99;
         end
         cycle();
         checks++;
         if (bus.warpActive_o !== expActive) begin failures++; $display("[TB] FAIL exit_active c=%0d got=%b exp=%b", c, bus.warpActive_o, expActive); end
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL exit_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (bus.fetchValid_o === 1'b1 && bus.fetchWarp_o === 2'd1) nW1++;
      end
      checks++;
      if (bus.warpActive_o[1] !== 1'b0 || nW1 !== 0) begin failures++; $display("[TB] FAIL exit_w1 got=%0b/%0d exp=0/0", bus.warpActive_o[1], nW1); end
   endtask

   task automatic test_stall();
      bit seen = 1'b0;
      for (int c = 0; c < 7; c++) begin
         idleInputs();
         bus.stall_i = (c < 3);
         if (c == 1) begin
            bus.reconv_i = 1'b1; bus.reconvWarp_i = 2'd0; bus.reconvPC_i = 32'h80;
            bus.ibufRelease_i = 1'b1; bus.ibufReleaseWarp_i = 2'd2;
         end
         cycle();
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL stall_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (expValid) begin
            checks++;
            if (bus.fetchWarp_o !== warp_id_t'(expWarp) || bus.fetchPC_o !== expPC) begin
               failures++; $display("[TB] FAIL stall_fetch c=%0d got=w%0d/%h exp=w%0d/%h", c, bus.fetchWarp_o, bus.fetchPC_o, expWarp, expPC);
            end
         end
         if (c == 3) begin
            seen = 1'b1;
            checks++;
            if (bus.fetchValid_o !== 1'b1 || bus.fetchWarp_o !== 2'd0 || bus.fetchPC_o !== 32'h80) begin
               failures++; $display("[TB] FAIL stall_first got=%0b/w%0d/%h exp=1/w0/80", bus.fetchValid_o, bus.fetchWarp_o, bus.fetchPC_o);
            end
         end
      end
      idleInputs();
      if (!seen) begin failures++; $display("[TB] FAIL stall_first got=none exp=w0"); end
   endtask

   task automatic test_pc_wrap();
      int nW3 = 0;
      bus.warpRunEnable_i = 4'b1111;
      for (int c = 0; c < 10; c++) begin
         idleInputs();
         if (c == 1) begin bus.reconv_i = 1'b1; bus.reconvWarp_i = 2'd3; bus.reconvPC_i = 32'hFFFF_FFFE; end
         cycle();
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL wrap_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (c >= 2 && bus.fetchValid_o === 1'b1 && bus.fetchWarp_o === 2'd3) begin
            checks++;
            if (nW3 == 0 && (bus.fetchPC_o !== 32'hFFFF_FFFE || bus.fetchPCadd1_o !== 32'hFFFF_FFFF)) begin
               failures++; $display("[TB] FAIL wrap_first got=%h/%h exp=fffffffe/ffffffff", bus.fetchPC_o, bus.fetchPCadd1_o);
            end else if (nW3 == 1 && (bus.fetchPC_o !== 32'h0 || bus.fetchPCadd1_o !== 32'h1)) begin
               failures++; $display("[TB] FAIL wrap_second got=%h/%h exp=0/1", bus.fetchPC_o, bus.fetchPCadd1_o);
            end
            nW3++;
         end
      end
      checks++;
      if (nW3 !== 2) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=2", nW3); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         int w;
         idleInputs();
         bus.stall_i = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0)
            bus.warpRunEnable_i = bus.warpRunEnable_i ^ 4'(1 << $urandom_range(0, 3));
         if ($urandom_range(0, 11) == 0) begin
            bus.ctaExit_i = 1'b1; bus.exitWarp_i = 2'($urandom_range(0, 3));
         end
         w = $urandom_range(0, 3);
         if ($urandom_range(0, 5) == 0 && mActive[w]) begin
            bus.reconv_i = 1'b1; bus.reconvWarp_i = 2'(w); bus.reconvPC_i = $urandom;
         end
         w = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 0 && mActive[w] && mCredit[w] < IBUF_DEPTH) begin
            bus.ibufRelease_i = 1'b1; bus.ibufReleaseWarp_i = 2'(w);
         end
         cycle();
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL rand_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (expValid) begin
            checks++;
            if (bus.fetchWarp_o !== warp_id_t'(expWarp) || bus.fetchPC_o !== expPC || bus.fetchPCadd1_o !== expPC + 32'd1) begin
               failures++; $display("[TB] FAIL rand_fetch c=%0d got=w%0d/%h/%h exp=w%0d/%h", c, bus.fetchWarp_o, bus.fetchPC_o, bus.fetchPCadd1_o, expWarp, expPC);
            end
         end
         checks++;
         if (bus.warpActive_o !== expActive) begin failures++; $display("[TB] FAIL rand_active c=%0d got=%b exp=%b", c, bus.warpActive_o, expActive); end
      end
      idleInputs();
   endtask

   task automatic test_async_reset();
      bus.warpRunEnable_i = 4'b0101;
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (bus.fetchValid_o !== 1'b0 || bus.fetchWarp_o !== '0 || bus.fetchPC_o !== '0 ||
          bus.fetchPCadd1_o !== '0 || bus.warpActive_o !== '0) begin
         failures++; $display("[TB] FAIL async_reset got=%0b/w%0d/%h/%h/%b exp=all zero", bus.fetchValid_o, bus.fetchWarp_o, bus.fetchPC_o, bus.fetchPCadd1_o, bus.warpActive_o);
      end
      modelReset();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cycle();
         checks++;
         if (bus.fetchValid_o !== expValid) begin failures++; $display("[TB] FAIL rst_valid c=%0d got=%0b exp=%0b", c, bus.fetchValid_o, expValid); end
         if (expValid) begin
            checks++;
            if (bus.fetchWarp_o !== warp_id_t'(expWarp) || bus.fetchPC_o !== expPC) begin
               failures++; $display("[TB] FAIL rst_fetch c=%0d got=w%0d/%h exp=w%0d/%h", c, bus.fetchWarp_o, bus.fetchPC_o, expWarp, expPC);
            end
         end
         checks++;
         if (bus.warpActive_o !== expActive) begin failures++; $display("[TB] FAIL rst_active c=%0d got=%b exp=%b", c, bus.warpActive_o, expActive); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_release();
      test_reconv();
      test_exit_reconv();
      test_stall();
      test_pc_wrap();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout exp=completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
